// File: rtl/hd_controller.sv
// Disk controller: tracks x sectors of words, modelled seek latency, Busy/Done handshake.
// Optional macro HD_WRITE_PROTECT_EN rejects writes to track 0.
module hd_controller #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned TRACKS       = 16,
  parameter int unsigned SECTOR_WORDS = 64,
  parameter int unsigned SEEK_CYCLES  = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [31:0]       Track,
  input  logic [31:0]       Offset,
  input  logic              ReadReq,
  input  logic              WriteReq,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              Busy,
  output logic              Done,
  output logic              AddrErr
);

  localparam int unsigned AW = $clog2(TRACKS * SECTOR_WORDS);
  localparam int unsigned TW = (TRACKS > 1) ? $clog2(TRACKS) : 1;
  localparam int unsigned OW = (SECTOR_WORDS > 1) ? $clog2(SECTOR_WORDS) : 1;
  localparam int unsigned CW = $clog2(SEEK_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSeek, StXfer} state_e;

  state_e            state_q;
  logic [CW-1:0]     seek_cnt_q;
  logic [TW-1:0]     track_q;
  logic [OW-1:0]     offset_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_write_q;
  logic [TW-1:0]     last_track_q;
  logic              last_valid_q;

  logic [DATA_W-1:0] mem [TRACKS * SECTOR_WORDS];
  logic [AW-1:0]     addr;
  logic              range_ok;
  logic              protect_hit;
  logic              same_track;
  logic              mem_we;

  assign addr       = AW'(track_q) * AW'(SECTOR_WORDS) + AW'(offset_q);
  assign range_ok   = (Track < 32'(TRACKS)) && (Offset < 32'(SECTOR_WORDS));
  assign same_track = last_valid_q && (Track[TW-1:0] == last_track_q);
  assign mem_we     = (state_q == StXfer) && is_write_q;

`ifdef HD_WRITE_PROTECT_EN
  // Track 0 holds the OS/BIOS image; only reads may reach it.
  assign protect_hit = WriteReq && (Track == 32'd0);
`else
  assign protect_hit = 1'b0;
`endif

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[addr] <= wdata_q;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= StIdle;
      seek_cnt_q   <= '0;
      track_q      <= '0;
      offset_q     <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      last_track_q <= '0;
      last_valid_q <= 1'b0;
      RdData       <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      AddrErr      <= 1'b0;
    end else begin
      Done    <= 1'b0;
      AddrErr <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ReadReq || WriteReq) begin
            if (!range_ok || protect_hit) begin
              AddrErr <= 1'b1;
            end else begin
              track_q    <= Track[TW-1:0];
              offset_q   <= Offset[OW-1:0];
              wdata_q    <= WrData;
              is_write_q <= WriteReq;
              seek_cnt_q <= same_track ? CW'(1) : CW'(SEEK_CYCLES);
              Busy       <= 1'b1;
              state_q    <= StSeek;
            end
          end
        end
        StSeek: begin
          seek_cnt_q <= seek_cnt_q - CW'(1);
          if (seek_cnt_q == CW'(1)) begin
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (!is_write_q) begin
            RdData <= mem[addr];
          end
          last_track_q <= track_q;
          last_valid_q <= 1'b1;
          Busy         <= 1'b0;
          Done         <= 1'b1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
